// File: rtl/midi_rx_parser.sv
// MIDI serial receiver (8N1, LSB first) with a channel-voice message parser
// (running status supported) and a single-entry valid/ready output register.
module midi_rx_parser #(
  parameter int unsigned BIT_CNT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  input  logic       msg_ready,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(BIT_CNT);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CNT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CNT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_e;

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_stb_q, byte_stb_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      rs_q, rs_d;
  logic            dcnt_q, dcnt_d;
  logic [6:0]      d1_q, d1_d;
  logic            msg_valid_q, msg_valid_d;
  logic [7:0]      msg_status_q, msg_status_d;
  logic [6:0]      msg_data1_q, msg_data1_d;
  logic [6:0]      msg_data2_q, msg_data2_d;
  logic            overrun_q, overrun_d;
  logic            line;
  logic            done;
  logic            one_byte;
  logic [6:0]      new_d1, new_d2;

  assign line = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_stb_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rs_q         <= '0;
      dcnt_q       <= 1'b0;
      d1_q         <= '0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= '0;
      msg_data1_q  <= '0;
      msg_data2_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], midi_rx};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_stb_q   <= byte_stb_d;
      frame_err_q  <= frame_err_d;
      rs_q         <= rs_d;
      dcnt_q       <= dcnt_d;
      d1_q         <= d1_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!line) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = line ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (line) begin
            byte_stb_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (line) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // shift_q stays stable for the strobe cycle: DATA is at least half a bit away.
  always_comb begin
    rs_d     = rs_q;
    dcnt_d   = dcnt_q;
    d1_d     = d1_q;
    done     = 1'b0;
    new_d1   = d1_q;
    new_d2   = '0;
    one_byte = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
    if (byte_stb_q) begin
      if (shift_q[7]) begin
        if (shift_q[7:4] != 4'hF) begin
          rs_d   = shift_q;
          dcnt_d = 1'b0;
        end else if (!shift_q[3]) begin
          rs_d   = '0;
          dcnt_d = 1'b0;
        end
      end else if (rs_q[7]) begin
        if (dcnt_q) begin
          done   = 1'b1;
          new_d2 = shift_q[6:0];
          dcnt_d = 1'b0;
        end else if (one_byte) begin
          done   = 1'b1;
          new_d1 = shift_q[6:0];
        end else begin
          d1_d   = shift_q[6:0];
          dcnt_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    msg_valid_d  = msg_valid_q;
    msg_status_d = msg_status_q;
    msg_data1_d  = msg_data1_q;
    msg_data2_d  = msg_data2_q;
    overrun_d    = 1'b0;
    if (done) begin
      if (!msg_valid_q || msg_ready) begin
        msg_valid_d  = 1'b1;
        msg_status_d = rs_q;
        msg_data1_d  = new_d1;
        msg_data2_d  = new_d2;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (msg_valid_q && msg_ready) begin
      msg_valid_d = 1'b0;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_status = msg_status_q;
  assign msg_data1  = msg_data1_q;
  assign msg_data2  = msg_data2_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Randomized scoreboard bench for midi_rx_parser: a byte-level MIDI model
// predicts messages, a monitor checks them on each accepted handshake.
module tb_midi_rx_parser;

  localparam int unsigned BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       midi_rx = 1'b1;
  logic       msg_ready = 1'b0;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  midi_rx_parser #(.BIT_CNT(BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .midi_rx   (midi_rx),
    .msg_ready (msg_ready),
    .msg_valid (msg_valid),
    .msg_status(msg_status),
    .msg_data1 (msg_data1),
    .msg_data2 (msg_data2),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int errors = 0;
  int checks = 0;
  int fe_seen = 0, ovr_seen = 0, exp_fe = 0, exp_ovr = 0;
  logic [21:0] exp_q[$];
  logic [7:0]  rs = 8'h00;
  logic [6:0]  dq[$];
  bit          hold_mode = 0, hold_full = 0, rand_ready = 0;
  bit          prev_hold = 0;
  logic [21:0] prev_msg = '0;
  logic [21:0] cur;

  assign cur = {msg_status, msg_data1, msg_data2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) fe_seen++;
    if (overrun) ovr_seen++;
    if (prev_hold && rst) check("held_msg", 32'(cur), 32'(prev_msg));
    prev_hold = msg_valid && !msg_ready && rst;
    prev_msg  = cur;
    if (msg_valid && msg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_msg: got %h, wanted none", cur);
      end else begin
        check("msg", 32'(cur), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic void model_complete(input logic [21:0] m);
    if (hold_mode && hold_full) exp_ovr++;
    else begin
      exp_q.push_back(m);
      if (hold_mode) hold_full = 1;
    end
  endfunction

  // MIDI semantics: status sets running status, system common cancels it,
  // real-time is transparent, data collects until the message length is met.
  function automatic void model_byte(input logic [7:0] b);
    int len;
    if (b >= 8'h80 && b <= 8'hEF) begin
      rs = b;
      dq.delete();
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      rs = 8'h00;
      dq.delete();
    end else if (b < 8'h80 && rs != 8'h00) begin
      dq.push_back(b[6:0]);
      len = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
      if (dq.size() == len) begin
        model_complete({rs, dq[0], (len == 2) ? dq[1] : 7'h00});
        dq.delete();
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) msg_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) model_byte(b);
    else exp_fe++;
    midi_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(BIT);
    end
    midi_rx = stop;
    tick(BIT);
    midi_rx = 1'b1;
    tick(4);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] part;
    tick(5);
    check("rst_valid", 32'(msg_valid), 32'd0);
    check("rst_status", 32'(msg_status), 32'd0);
    check("rst_data1", 32'(msg_data1), 32'd0);
    check("rst_data2", 32'(msg_data2), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick(5);

    msg_ready = 1'b1;
    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    drain("drain_basic");
    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    send_byte(8'h2F, 1); send_byte(8'h40, 1);
    drain("drain_running");
    send_byte(8'hC5, 1); send_byte(8'h10, 1); send_byte(8'h90, 1);
    send_byte(8'hF8, 1); send_byte(8'h3C, 1); send_byte(8'h64, 1);
    drain("drain_realtime");

    midi_rx = 1'b0;
    tick(3);
    midi_rx = 1'b1;
    tick(3 * BIT);
    send_byte(8'h55, 0);
    tick(3 * BIT);
    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    drain("drain_after_err");
    check("frame_err_cnt", 32'(fe_seen), 32'(exp_fe));

    msg_ready = 1'b0;
    hold_mode = 1;
    hold_full = 0;
    send_byte(8'hB0, 1); send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    send_byte(8'hB0, 1); send_byte(8'h2F, 1); send_byte(8'h7F, 1);
    tick(20);
    check("hold_valid", 32'(msg_valid), 32'd1);
    check("overrun_cnt_hold", 32'(ovr_seen), 32'(exp_ovr));
    msg_ready = 1'b1;
    tick(1);
    check("valid_drop", 32'(msg_valid), 32'd0);
    hold_mode = 0;
    drain("drain_hold");

    rand_ready = 1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(8'h80, 8'hEF));
        6, 7:             b = 8'($urandom_range(8'hF8, 8'hFF));
        8:                b = 8'($urandom_range(8'hF0, 8'hF7));
        default:          b = 8'($urandom_range(0, 8'h7F));
      endcase
      send_byte(b, 1);
    end
    rand_ready = 0;
    msg_ready = 1'b1;
    drain("drain_random");
    check("overrun_cnt", 32'(ovr_seen), 32'(exp_ovr));
    check("frame_err_cnt_end", 32'(fe_seen), 32'(exp_fe));

    send_byte(8'hB0, 1);
    part = 8'h2E;
    midi_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 3; i++) begin
      midi_rx = part[i];
      tick(BIT);
    end
    rst = 1'b0;
    midi_rx = 1'b1;
    rs = 8'h00;
    dq.delete();
    tick(2);
    check("rst_mid_outputs", 32'({msg_valid, msg_status, msg_data1, msg_data2, frame_err, overrun}),
          32'd0);
    rst = 1'b1;
    tick(4);
    send_byte(8'h2E, 1); send_byte(8'h7F, 1);
    tick(4 * BIT);
    drain("drain_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
